// File: rtl/flappy_pkg.sv
// Shared types, game constants and the score digit decoder for the Flappy Bird core.
package flappy_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } game_state_e;

    localparam logic [3:0] BIRD_COL     = 4'd2;
    localparam logic [3:0] GAP_H        = 4'd4;
    localparam logic [3:0] BIRD_RST_ROW = 4'd7;
    localparam logic [3:0] FLAP_ROWS    = 4'd2;
    localparam logic [3:0] PIPE_RST_COL = 4'd15;
    localparam logic [3:0] GAP_RST_TOP  = 4'd6;
    localparam logic [7:0] LFSR_SEED    = 8'h01;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8
    import flappy_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] value_o
);

    logic [7:0] value_q;
    logic       feedback;

    assign feedback = value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3];
    assign value_o  = value_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= {value_q[6:0], feedback};
        end
    end

endmodule

// File: rtl/flappy_bird_game.sv
// Flappy Bird game core: bird, one scrolling pipe, collision, BCD score and
// LED-matrix / seven-segment decodes, all clocked on CLOCK_50.
module flappy_bird_game
    import flappy_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             bird_clk,
    input  logic             pipe_clock,
    input  logic             press,
    output logic [15:0][15:0] GrnPixels,
    output logic [15:0][15:0] RedPixels,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX3
);

    game_state_e     state_q;
    logic [3:0]      row_q, pipe_col_q, gap_top_q;
    logic [2:0][3:0] score_q;
    logic            press_s1_q, press_s2_q, press_prev_q;
    logic            bird_s_q, bird_prev_q, pipe_s_q, pipe_prev_q;

    logic            press_edge, bird_edge, pipe_edge;
    logic [3:0]      flap_row, gap_bot;
    logic            collide;
    logic [2:0][3:0] score_inc;
    logic [7:0]      lfsr;
    logic            unused_lfsr;

    lfsr8 u_lfsr (
        .clk_i  (CLOCK_50),
        .rst_ni (rst),
        .value_o(lfsr)
    );

    assign unused_lfsr = ^lfsr[7:3];

    assign press_edge = press_s2_q & ~press_prev_q;
    assign bird_edge  = bird_s_q & ~bird_prev_q;
    assign pipe_edge  = pipe_s_q & ~pipe_prev_q;
    assign flap_row   = (row_q >= FLAP_ROWS) ? row_q - FLAP_ROWS : 4'd0;
    assign gap_bot    = gap_top_q + GAP_H - 4'd1;
    assign collide    = (pipe_col_q == BIRD_COL) && ((row_q < gap_top_q) || (row_q > gap_bot));

    // Saturating 3-digit BCD increment.
    always_comb begin
        score_inc = score_q;
        if (score_q != 12'h999) begin
            if (score_q[0] != 4'd9) begin
                score_inc[0] = score_q[0] + 4'd1;
            end else begin
                score_inc[0] = 4'd0;
                if (score_q[1] != 4'd9) begin
                    score_inc[1] = score_q[1] + 4'd1;
                end else begin
                    score_inc[1] = 4'd0;
                    score_inc[2] = score_q[2] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            state_q      <= StIdle;
            row_q        <= BIRD_RST_ROW;
            pipe_col_q   <= PIPE_RST_COL;
            gap_top_q    <= GAP_RST_TOP;
            score_q      <= '0;
            press_s1_q   <= 1'b0;
            press_s2_q   <= 1'b0;
            press_prev_q <= 1'b0;
            bird_s_q     <= 1'b0;
            bird_prev_q  <= 1'b0;
            pipe_s_q     <= 1'b0;
            pipe_prev_q  <= 1'b0;
        end else begin
            press_s1_q   <= press;
            press_s2_q   <= press_s1_q;
            press_prev_q <= press_s2_q;
            bird_s_q     <= bird_clk;
            bird_prev_q  <= bird_s_q;
            pipe_s_q     <= pipe_clock;
            pipe_prev_q  <= pipe_s_q;

            case (state_q)
                StIdle: begin
                    if (press_edge) begin
                        state_q <= StPlay;
                        row_q   <= flap_row;
                    end
                end
                StPlay: begin
                    // A collision freezes the whole game on the edge it is seen.
                    if (collide) begin
                        state_q <= StOver;
                    end else begin
                        if (press_edge) begin
                            row_q <= flap_row;
                        end else if (bird_edge) begin
                            row_q <= row_q + 4'd1;
                            if (row_q == 4'd14) begin
                                state_q <= StOver;
                            end
                        end
                        if (pipe_edge) begin
                            if (pipe_col_q == 4'd0) begin
                                pipe_col_q <= PIPE_RST_COL;
                                gap_top_q  <= {1'b0, lfsr[2:0]} + 4'd2;
                            end else begin
                                pipe_col_q <= pipe_col_q - 4'd1;
                                if (pipe_col_q == BIRD_COL) begin
                                    score_q <= score_inc;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        RedPixels = '0;
        RedPixels[row_q][BIRD_COL] = 1'b1;
    end

    always_comb begin
        GrnPixels = '0;
        for (int r = 0; r < 16; r++) begin
            if ((4'(r) < gap_top_q) || (4'(r) > gap_bot)) begin
                GrnPixels[r][pipe_col_q] = 1'b1;
            end
        end
    end

    assign HEX5 = bcd_to_seg(score_q[2]);
    assign HEX4 = bcd_to_seg(score_q[1]);
    assign HEX3 = bcd_to_seg(score_q[0]);

endmodule

// File: tb/tb_flappy_bird_game.sv
// Directed plus randomized bench for flappy_bird_game against a cycle-level game model.
module tb_flappy_bird_game;

    typedef logic [15:0][15:0] frame_t;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

    logic CLOCK_50 = 1'b0;
    logic rst = 1'b0, bird_clk = 1'b0, pipe_clock = 1'b0, press = 1'b0;
    frame_t GrnPixels, RedPixels;
    logic [6:0] HEX5, HEX4, HEX3;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int m_state = M_IDLE, m_row = 7, m_col = 15, m_gap = 6, m_score = 0;
    logic [7:0] m_lfsr = 8'h01;
    logic p1 = 0, p2 = 0, p3 = 0, b1 = 0, b2 = 0, c1 = 0, c2 = 0;

    flappy_bird_game dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .bird_clk  (bird_clk),
        .pipe_clock(pipe_clock),
        .press     (press),
        .GrnPixels (GrnPixels),
        .RedPixels (RedPixels),
        .HEX5      (HEX5),
        .HEX4      (HEX4),
        .HEX3      (HEX3)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic frame_t red_at(input int r);
        frame_t f = '0;
        f[r][2] = 1'b1;
        return f;
    endfunction

    function automatic frame_t grn_of(input int col, input int gap);
        frame_t f = '0;
        for (int r = 0; r < 16; r++) begin
            if (r < gap || r > gap + 3) f[r][col] = 1'b1;
        end
        return f;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_row = 7; m_col = 15; m_gap = 6; m_score = 0; m_lfsr = 8'h01;
        p1 = 0; p2 = 0; p3 = 0; b1 = 0; b2 = 0; c1 = 0; c2 = 0;
    endtask

    // Press acts 3 edges after it is first sampled high, ticks act 2 edges after.
    task automatic model_edge();
        bit press_ev, bird_ev, pipe_ev, hit;
        if (!rst) begin
            model_reset();
            return;
        end
        press_ev = p2 && !p3;
        bird_ev  = b1 && !b2;
        pipe_ev  = c1 && !c2;
        if (m_state == M_IDLE) begin
            if (press_ev) begin
                m_state = M_PLAY;
                m_row = (m_row >= 2) ? m_row - 2 : 0;
            end
        end else if (m_state == M_PLAY) begin
            hit = (m_col == 2) && (m_row < m_gap || m_row > m_gap + 3);
            if (hit) begin
                m_state = M_OVER;
            end else begin
                if (press_ev) begin
                    m_row = (m_row >= 2) ? m_row - 2 : 0;
                end else if (bird_ev) begin
                    m_row++;
                    if (m_row == 15) m_state = M_OVER;
                end
                if (pipe_ev) begin
                    if (m_col == 0) begin
                        m_col = 15;
                        m_gap = int'(m_lfsr[2:0]) + 2;
                    end else begin
                        if (m_col == 2 && m_score < 999) m_score++;
                        m_col--;
                    end
                end
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
        p3 = p2; p2 = p1; p1 = press;
        b2 = b1; b1 = bird_clk;
        c2 = c1; c1 = pipe_clock;
    endtask

    task automatic chk_frame(input string tag, input frame_t obs, input frame_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk_frame("model_red", RedPixels, red_at(m_row));
        chk_frame("model_grn", GrnPixels, grn_of(m_col, m_gap));
        chk_seg("model_hex5", HEX5, SEG[m_score / 100]);
        chk_seg("model_hex4", HEX4, SEG[(m_score / 10) % 10]);
        chk_seg("model_hex3", HEX3, SEG[m_score % 10]);
    endtask

    task automatic check_reset_values(input string tag);
        chk_frame({tag, "_red"}, RedPixels, red_at(7));
        chk_frame({tag, "_grn"}, GrnPixels, grn_of(15, 6));
        chk_seg({tag, "_hex5"}, HEX5, 7'b1000000);
        chk_seg({tag, "_hex4"}, HEX4, 7'b1000000);
        chk_seg({tag, "_hex3"}, HEX3, 7'b1000000);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_pulse();
        press = 1'b1; step(); press = 1'b0; run(3);
    endtask

    task automatic bird_tick();
        bird_clk = 1'b1; step(); bird_clk = 1'b0; run(2);
    endtask

    task automatic pipe_tick();
        pipe_clock = 1'b1; step(); pipe_clock = 1'b0; run(2);
    endtask

    task automatic do_reset();
        rst = 1'b0; run(3); rst = 1'b1; run(1);
    endtask

    initial begin
        frame_t snap_g, snap_r;
        logic [6:0] snap5, snap4, snap3;
        logic [7:0] nx;
        int guard;

        // Reset held low with ticks toggling, then ticks in IDLE.
        rst = 1'b0;
        bird_clk = 1'b1; pipe_clock = 1'b1; step();
        bird_clk = 1'b0; pipe_clock = 1'b0; run(2);
        check_reset_values("reset");
        rst = 1'b1; run(1);
        bird_tick(); pipe_tick();
        check_reset_values("idle_ticks");

        // Start flap then gravity.
        press_pulse();
        chk_frame("start_flap", RedPixels, red_at(5));
        bird_tick(); chk_frame("fall6", RedPixels, red_at(6));
        bird_tick(); chk_frame("fall7", RedPixels, red_at(7));
        bird_tick(); chk_frame("fall8", RedPixels, red_at(8));

        // Flap and tick together at row 1, then flap at the ceiling.
        do_reset();
        press_pulse(); press_pulse(); press_pulse();
        chk_frame("row1", RedPixels, red_at(1));
        press = 1'b1; step();
        press = 1'b0; bird_clk = 1'b1; step();
        bird_clk = 1'b0; run(2);
        chk_frame("flap_beats_fall", RedPixels, red_at(0));
        press_pulse();
        chk_frame("ceiling", RedPixels, red_at(0));

        // Fall to the floor, then everything frozen.
        for (int i = 0; i < 15; i++) bird_tick();
        chk_frame("floor", RedPixels, red_at(15));
        snap_g = GrnPixels; snap_r = RedPixels;
        snap5 = HEX5; snap4 = HEX4; snap3 = HEX3;
        for (int i = 0; i < 20; i++) begin
            press = 1'($urandom_range(0, 1));
            bird_clk = 1'($urandom_range(0, 1));
            pipe_clock = 1'($urandom_range(0, 1));
            step();
        end
        press = 1'b0; bird_clk = 1'b0; pipe_clock = 1'b0; run(3);
        chk_frame("over_red", RedPixels, snap_r);
        chk_frame("over_grn", GrnPixels, snap_g);
        chk_seg("over_hex5", HEX5, snap5);
        chk_seg("over_hex4", HEX4, snap4);
        chk_seg("over_hex3", HEX3, snap3);

        // Pass through the reset gap and score.
        do_reset();
        press_pulse(); bird_tick(); bird_tick();
        chk_frame("row7", RedPixels, red_at(7));
        for (int i = 0; i < 13; i++) pipe_tick();
        chk_seg("pre_score", HEX3, 7'b1000000);
        pipe_tick();
        chk_frame("col1", GrnPixels, grn_of(1, 6));
        chk_seg("score1", HEX3, 7'b1111001);

        // Wrap with gap 2..5, bird at 12, collide at column 2.
        pipe_tick();
        for (int i = 0; i < 5; i++) bird_tick();
        chk_frame("row12", RedPixels, red_at(12));
        guard = 0;
        nx = lfsr_next(m_lfsr);
        while (nx[2:0] != 3'd0 && guard < 600) begin
            step(); guard++; nx = lfsr_next(m_lfsr);
        end
        vectors++;
        assert (guard < 600) else begin
            miscompares++;
            $error("FAIL lfsr_wait: observed %0d cycles expected < 600", guard);
        end
        pipe_clock = 1'b1; step(); pipe_clock = 1'b0; run(2);
        chk_frame("wrap_gap2", GrnPixels, grn_of(15, 2));
        for (int i = 0; i < 13; i++) pipe_tick();
        chk_frame("collide_col2", GrnPixels, grn_of(2, 2));
        pipe_tick(); pipe_tick(); bird_tick(); press_pulse();
        chk_frame("collide_frozen_grn", GrnPixels, grn_of(2, 2));
        chk_frame("collide_frozen_red", RedPixels, red_at(12));
        chk_seg("collide_score", HEX3, 7'b1111001);
        rst = 1'b0; step();
        check_reset_values("mid_over_reset");
        rst = 1'b1; run(1);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            press = ($urandom_range(0, 7) == 0);
            bird_clk = ($urandom_range(0, 3) == 0);
            pipe_clock = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
